// File: rtl/nes_pad_responder.sv
// Virtual NES joypad: debounced board buttons are parallel-loaded into a
// 4021-style shift register while latch is high and shifted out on pulse rises.
module nes_pad_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] buttons_raw,
  input  logic       ctlr_latch,
  input  logic       ctlr_pulse,
  output logic       ctlr_data,
  output logic [7:0] buttons_db,
  output logic [3:0] bit_count
);

  localparam bit              NO_DEBOUNCE = (DEBOUNCE_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NO_DEBOUNCE ? 0 : DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Two-flop synchronizers; pulse side idles high like the console pin.
  logic       latch_meta_q, latch_s_q;
  logic       pulse_meta_q, pulse_s_q, pulse_prev_q;
  logic [7:0] btn_meta_q, btn_s_q;

  logic [7:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  logic [7:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       pulse_rise;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latch_meta_q <= 1'b0;
      latch_s_q    <= 1'b0;
      pulse_meta_q <= 1'b1;
      pulse_s_q    <= 1'b1;
      pulse_prev_q <= 1'b1;
      btn_meta_q   <= 8'h00;
      btn_s_q      <= 8'h00;
    end else begin
      latch_meta_q <= ctlr_latch;
      latch_s_q    <= latch_meta_q;
      pulse_meta_q <= ctlr_pulse;
      pulse_s_q    <= pulse_meta_q;
      pulse_prev_q <= pulse_s_q;
      btn_meta_q   <= buttons_raw;
      btn_s_q      <= btn_meta_q;
    end
  end

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (NO_DEBOUNCE) begin
        db_d[i]  = btn_s_q[i];
        cnt_d[i] = '0;
      end else if (btn_s_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = btn_s_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_q <= 8'h00;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pulse_rise = pulse_s_q & ~pulse_prev_q;

  // Latch dominates: the register stays transparent and any pulse is dropped.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (latch_s_q) begin
      sr_d      = ~db_q;
      bit_cnt_d = 4'd0;
    end else if (pulse_rise) begin
      sr_d = {1'b0, sr_q[7:1]};
      if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q      <= 8'hFF;
      bit_cnt_q <= 4'd0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign ctlr_data  = sr_q[0];
  assign buttons_db = db_q;
  assign bit_count  = bit_cnt_q;

endmodule
